uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_SIZE, default 8, sets the data bits per frame and the width of fifo_data.
REQ-002 Parameter DVSR, default 163, sets the clk cycles per oversample tick (16 ticks per bit).
REQ-003 Parameter SB_TICKS, default 16, sets the stop-bit length in ticks (16 = 1 stop bit, 32 = 2 stop bits).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 fifo_empty  input  1  high when the upstream FIFO holds no word.
REQ-007 fifo_data  input  DATA_SIZE  head-of-FIFO word, valid whenever fifo_empty=0 (show-ahead).
REQ-008 fifo_rd  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-011 tx_done_tick  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 The baud counter SHALL count 0..DVSR-1 and wrap, asserting an internal tick in the cycle where count==DVSR-1.
REQ-014 The baud counter and the tick counter s SHALL both clear to 0 in the cycle the FSM leaves IDLE, so every bit lasts exactly 16*DVSR clk cycles.
REQ-015 In IDLE with fifo_empty=1, the block SHALL hold tx=1 and fifo_rd=0, and SHALL remain in IDLE.
REQ-016 In IDLE with fifo_empty=0, the block SHALL assert fifo_rd for exactly that one cycle, load fifo_data into the shift register on the same edge, and move to START.
REQ-017 fifo_data SHALL be sampled only in the fifo_rd cycle; later changes to fifo_data SHALL NOT affect the frame in progress.
REQ-018 In START, tx SHALL be 0; on the tick where s==15, s SHALL clear, the bit index n SHALL clear, and the FSM SHALL move to DATA.
REQ-019 In DATA, tx SHALL equal shift register bit 0, so data goes out LSB first.
REQ-020 In DATA, on the tick where s==15, the shift register SHALL shift right by one and s SHALL clear.
REQ-021 On that same tick, n SHALL increment if n<DATA_SIZE-1; otherwise the FSM SHALL move to STOP.
REQ-022 In STOP, tx SHALL be 1; on the tick where s==SB_TICKS-1, tx_done_tick SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-023 Back-to-back frames: if fifo_empty=0 in the first IDLE cycle after STOP, the next fifo_rd SHALL occur in that cycle, giving exactly one idle-high clk between frames.
REQ-024 fifo_rd SHALL never assert while fifo_empty=1, and SHALL never assert outside IDLE.
REQ-025 The s counter SHALL be 6 bits wide, enough for SB_TICKS up to 64.
REQ-026 n SHALL be $clog2(DATA_SIZE) bits wide; the baud counter SHALL be $clog2(DVSR) bits wide; all counters SHALL wrap modulo their terminal value only as stated above.
REQ-027 tx SHALL be driven from a register so it is glitch-free.
REQ-028 Total frame length SHALL be (16*(1+DATA_SIZE)+SB_TICKS)*DVSR clk cycles.

Reset
REQ-029 While reset=0, the FSM SHALL be in IDLE and all counters and the shift register SHALL be 0.
REQ-030 While reset=0, tx=1, fifo_rd=0, tx_busy=0 and tx_done_tick=0, independent of clk.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; the popped word is discarded and SHALL NOT be retransmitted.
REQ-032 After reset deasserts, the first fifo_rd SHALL occur no earlier than the first rising clk edge with fifo_empty=0.

Verification
REQ-033 DVSR=4, SB_TICKS=16, fifo_data=0xA5, fifo_empty falls -> one fifo_rd pulse; tx holds 0 for 64 clk; data bits 1,0,1,0,0,1,0,1 each for 64 clk; stop bit 1 for 64 clk; tx_done_tick at clk 640 after fifo_rd.
REQ-034 Two words 0x00 and 0xFF pre-loaded, fifo_empty stays 0 -> two fifo_rd pulses 641 clk apart; exactly 1 idle-high clk between the two frames.
REQ-035 fifo_data changed to 0x3C one clk after the pop of 0x5A -> the line carries 0x5A.
REQ-036 reset pulsed low during data bit 3 -> tx=1 and tx_busy=0 asynchronously; no tx_done_tick; with fifo_empty=1 after release, the line stays idle.
REQ-037 SB_TICKS=32, DVSR=4, word 0x81 -> stop bit lasts 128 clk; frame is 704 clk.
REQ-038 fifo_empty held at 1 for 1000 clk after reset -> fifo_rd, tx_busy and tx_done_tick stay 0; tx stays 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter that pulls words from an upstream show-ahead FIFO and
//   serialises them as 1 start bit, DATA_SIZE data bits (LSB first) and a
//   stop bit of SB_TICKS oversample ticks. One oversample tick is DVSR clk
//   cycles and every start/data bit lasts 16 ticks.
//
// Parameters
//   DATA_SIZE  data bits per frame / width of fifo_data
//   DVSR       clk cycles per oversample tick
//   SB_TICKS   stop-bit length in ticks (16 = 1 stop bit, 32 = 2 stop bits, max 64)
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-low reset
//   fifo_empty    in   upstream FIFO holds no word
//   fifo_data     in   head-of-FIFO word, valid whenever fifo_empty=0
//   fifo_rd       out  one-cycle pop strobe to the upstream FIFO
//   tx            out  serial line, idle high, driven from a flop
//   tx_busy       out  frame in progress (FSM not in IDLE)
//   tx_done_tick  out  one-cycle pulse on the last tick of the stop bit
module uart_tx_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int DVSR      = 163,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    // Degenerate parameter values (DVSR=1, DATA_SIZE=1) would give zero-width
    // counters, so keep at least one bit.
    localparam int BW = (DVSR > 1)      ? $clog2(DVSR)      : 1;
    localparam int NW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DVSR - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_SIZE - 1);
    localparam logic [5:0]    S_BIT_LAST  = 6'd15;
    localparam logic [5:0]    S_STOP_LAST = 6'(SB_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [BW-1:0]        baud;
    logic [5:0]           s;
    logic [NW-1:0]        n;
    logic [DATA_SIZE-1:0] shreg;
    logic [DATA_SIZE-1:0] shreg_nxt;
    logic                 tx_q;
    logic                 tick;

    assign tick      = (baud == BAUD_LAST);
    assign shreg_nxt = shreg >> 1;

    // Pop is decoded from the registered state so the pop and the load of
    // fifo_data land on the same edge. Gating with reset keeps the strobe low
    // while reset is held even if the FIFO already has data.
    assign fifo_rd      = reset && (state == IDLE) && !fifo_empty;
    assign tx_busy      = (state != IDLE);
    assign tx_done_tick = (state == STOP) && tick && (s == S_STOP_LAST);
    assign tx           = tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            baud  <= '0;
            s     <= '0;
            n     <= '0;
            shreg <= '0;
            tx_q  <= 1'b1;
        end else begin
            // Baud counter is held at 0 in IDLE so the first tick of a frame
            // comes exactly DVSR cycles after leaving IDLE.
            if (state == IDLE || tick)
                baud <= '0;
            else
                baud <= baud + 1'b1;

            case (state)
                IDLE: begin
                    s    <= '0;
                    n    <= '0;
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shreg <= fifo_data;
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            tx_q  <= shreg[0];
                            state <= DATA;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            shreg <= shreg_nxt;
                            if (n == N_LAST) begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end else begin
                                n    <= n + 1'b1;
                                // Next data bit is the new LSB after the shift.
                                tx_q <= shreg_nxt[0];
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (s == S_STOP_LAST) begin
                            s     <= '0;
                            state <= IDLE;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Two instances: dut (1 stop bit) and dut32 (2 stop bits), both DVSR=4.
//   Each is fed from a bench-side show-ahead FIFO queue. A frame-level model
//   predicts every cycle's tx / tx_busy / fifo_rd / tx_done_tick from the
//   popped word and the cycle offset into the frame.
module tb_uart_tx_fifo;

    localparam int DS   = 8;
    localparam int DV   = 4;
    localparam int SB0  = 16;
    localparam int SB1  = 32;
    localparam int BITC = 16 * DV;
    localparam int L0   = (16 * (1 + DS) + SB0) * DV;
    localparam int L1   = (16 * (1 + DS) + SB1) * DV;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          fe0 = 1'b1, fe1 = 1'b1;
    logic [DS-1:0] fd0 = '0,   fd1 = '0;
    logic          rd0, rd1, tx0, tx1, bz0, bz1, dn0, dn1;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_SIZE(DS), .DVSR(DV), .SB_TICKS(SB0)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fe0), .fifo_data(fd0),
        .fifo_rd(rd0), .tx(tx0), .tx_busy(bz0), .tx_done_tick(dn0)
    );

    uart_tx_fifo #(.DATA_SIZE(DS), .DVSR(DV), .SB_TICKS(SB1)) dut32 (
        .clk(clk), .reset(reset), .fifo_empty(fe1), .fifo_data(fd1),
        .fifo_rd(rd1), .tx(tx1), .tx_busy(bz1), .tx_done_tick(dn1)
    );

    int            n_chk = 0, n_fail = 0;
    int            cyc = 0;
    logic [7:0]    q0[$], q1[$];
    bit            m_busy[2];
    int            m_k[2];
    logic [7:0]    m_word[2];
    int            n_rd[2], n_dn[2], last_rd[2], prev_rd[2], last_dn[2];
    bit            fix_junk = 0;
    logic [7:0]    junk = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    // Line level at cycle k (1-based) after the pop: start, data LSB first, stop.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        int b;
        b = (k - 1) / BITC;
        if (b == 0)       return 1'b0;
        else if (b <= DS) return w[b-1];
        else              return 1'b1;
    endfunction

    task automatic model(input int i, input logic tx, input logic bz, input logic rd,
                         input logic dn, input int qsz, input logic [7:0] head, input int L);
        logic etx, ebz, erd, edn;
        string p;
        p = (i == 0) ? "d16" : "d32";
        if (!reset) begin
            etx = 1'b1; ebz = 1'b0; erd = 1'b0; edn = 1'b0;
            m_busy[i] = 0;
        end else if (m_busy[i]) begin
            m_k[i]++;
            etx = exp_bit(m_word[i], m_k[i]);
            ebz = 1'b1; erd = 1'b0;
            edn = (m_k[i] == L);
        end else begin
            etx = 1'b1; ebz = 1'b0; edn = 1'b0;
            erd = (qsz > 0);
        end
        chk({p, ".tx"},   tx, etx);
        chk({p, ".busy"}, bz, ebz);
        chk({p, ".rd"},   rd, erd);
        chk({p, ".done"}, dn, edn);
        if (reset) begin
            if (m_busy[i] && m_k[i] == L) begin
                m_busy[i] = 0;
            end else if (!m_busy[i] && erd) begin
                m_busy[i] = 1;
                m_k[i]    = 0;
                m_word[i] = head;
            end
        end
    endtask

    task automatic drive();
        fe0 = (q0.size() == 0);
        fd0 = fe0 ? (fix_junk ? junk : 8'($urandom)) : q0[0];
        fe1 = (q1.size() == 0);
        fd1 = fe1 ? 8'($urandom) : q1[0];
    endtask

    task automatic push0(input logic [7:0] w);
        q0.push_back(w);
        drive();
    endtask

    task automatic push1(input logic [7:0] w);
        q1.push_back(w);
        drive();
    endtask

    // One clock: check on the falling edge, pop/drive just after the rising edge.
    task automatic step();
        logic p0, p1;
        @(negedge clk);
        cyc++;
        model(0, tx0, bz0, rd0, dn0, q0.size(), fd0, L0);
        model(1, tx1, bz1, rd1, dn1, q1.size(), fd1, L1);
        p0 = rd0;
        p1 = rd1;
        if (rd0) begin n_rd[0]++; prev_rd[0] = last_rd[0]; last_rd[0] = cyc; end
        if (rd1) begin n_rd[1]++; prev_rd[1] = last_rd[1]; last_rd[1] = cyc; end
        if (dn0) begin n_dn[0]++; last_dn[0] = cyc; end
        if (dn1) begin n_dn[1]++; last_dn[1] = cyc; end
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy[0] || m_busy[1]) && t < maxc) begin
            step();
            t++;
        end
        chk({tag, ".timeout"}, 32'(t < maxc), 1);
        repeat (3) step();
    endtask

    initial begin
        int r0, d0, k;

        // Reset asserted before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst.tx",    tx0, 1);
        chk("rst.busy",  bz0, 0);
        chk("rst.rd",    rd0, 0);
        chk("rst.done",  dn0, 0);
        chk("rst.tx32",  tx1, 1);
        drive();
        repeat (3) step();
        #2 reset = 1'b1;

        // Long idle with an empty FIFO.
        repeat (1000) step();
        chk("idle.rd_cnt",   n_rd[0] + n_rd[1], 0);
        chk("idle.done_cnt", n_dn[0] + n_dn[1], 0);

        // Single 0xA5 frame.
        r0 = n_rd[0];
        push0(8'hA5);
        run_until_idle("a5", 2000);
        chk("a5.rd_cnt",   n_rd[0] - r0, 1);
        chk("a5.done_lat", last_dn[0] - last_rd[0], 640);

        // Back-to-back 0x00, 0xFF.
        r0 = n_rd[0];
        push0(8'h00);
        push0(8'hFF);
        run_until_idle("b2b", 3000);
        chk("b2b.rd_cnt", n_rd[0] - r0, 2);
        chk("b2b.rd_gap", last_rd[0] - prev_rd[0], 641);

        // fifo_data changes to 0x3C right after 0x5A is popped.
        fix_junk = 1;
        junk = 8'h3C;
        push0(8'h5A);
        run_until_idle("hold5a", 2000);
        fix_junk = 0;

        // Reset in the middle of data bit 3 of 0xC3.
        push0(8'hC3);
        k = 0;
        while (!(m_busy[0] && m_k[0] >= 4 * BITC + 10) && k < 1000) begin
            step();
            k++;
        end
        chk("rstmid.reached", 32'(k < 1000), 1);
        r0 = n_rd[0];
        d0 = n_dn[0];
        #2 reset = 1'b0;
        #1;
        chk("rstmid.tx",   tx0, 1);
        chk("rstmid.busy", bz0, 0);
        chk("rstmid.done", dn0, 0);
        repeat (4) step();
        #2 reset = 1'b1;
        repeat (200) step();
        chk("rstmid.rd_cnt",   n_rd[0] - r0, 0);
        chk("rstmid.done_cnt", n_dn[0] - d0, 0);
        chk("rstmid.tx_idle",  tx0, 1);

        // Two stop bits, word 0x81.
        push1(8'h81);
        run_until_idle("sb32", 2000);
        chk("sb32.frame_len", last_dn[1] - last_rd[1], 704);

        // Randomised traffic on both instances.
        repeat (12) begin
            if ($urandom_range(0, 1) == 1) push0(8'($urandom));
            if ($urandom_range(0, 2) == 0) push0(8'($urandom));
            if ($urandom_range(0, 2) == 0) push1(8'($urandom));
            k = $urandom_range(1, 900);
            repeat (k) step();
        end
        run_until_idle("rand", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
